// File: rtl/sdram_fifo_ctrl.sv
// Moves bursts from an external write FIFO into an SDRAM ring buffer and back out to a read FIFO.
// Write and read bursts are arbitrated round-robin, one burst at a time, with ring occupancy counted in whole bursts.
module sdram_fifo_ctrl #(
  parameter logic [9:0]  BURST       = 10'd10,
  parameter logic [23:0] ADDR_MIN    = 24'd0,
  parameter logic [23:0] ADDR_MAX    = 24'd999,
  parameter logic [9:0]  RD_FIFO_THR = 10'd512
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        init_end,
  input  logic        read_valid,
  input  logic [9:0]  wr_fifo_usedw,
  input  logic [15:0] wr_fifo_rd_data,
  output logic        wr_fifo_rd_en,
  input  logic [9:0]  rd_fifo_usedw,
  output logic        rd_fifo_wr_en,
  output logic [15:0] rd_fifo_wr_data,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_wr_addr,
  output logic [9:0]  wr_burst_len,
  output logic [15:0] sdram_wr_data,
  output logic        sdram_rd_req,
  input  logic        sdram_rd_ack,
  output logic [23:0] sdram_rd_addr,
  output logic [9:0]  rd_burst_len,
  input  logic [15:0] sdram_rd_data
);

  localparam logic [23:0] BURST_W   = {14'd0, BURST};
  localparam logic [23:0] SPAN      = ADDR_MAX - ADDR_MIN + 24'd1;
  localparam logic [23:0] CAP       = SPAN / BURST_W;
  localparam logic [23:0] WRAP_ADDR = ADDR_MAX - BURST_W + 24'd1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  typedef enum logic {GNT_WRITE, GNT_READ} grant_t;

  state_t      state;
  grant_t      last_grant;
  logic [23:0] level;
  logic        wr_ack_d1;
  logic        rd_ack_d1;
  logic        wr_ok;
  logic        rd_ok;
  logic        wr_ack_fall;
  logic        rd_ack_fall;

  // Data paths are pure wiring between the FIFOs and the SDRAM port
  assign wr_fifo_rd_en   = sdram_wr_ack;
  assign sdram_wr_data   = wr_fifo_rd_data;
  assign rd_fifo_wr_en   = sdram_rd_ack;
  assign rd_fifo_wr_data = sdram_rd_data;
  assign wr_burst_len    = BURST;
  assign rd_burst_len    = BURST;

  assign wr_ok       = (wr_fifo_usedw >= BURST) && (level < CAP);
  assign rd_ok       = read_valid && (rd_fifo_usedw < RD_FIFO_THR) && (level != 24'd0);
  assign wr_ack_fall = wr_ack_d1 && !sdram_wr_ack;
  assign rd_ack_fall = rd_ack_d1 && !sdram_rd_ack;

  function automatic logic [23:0] next_addr(input logic [23:0] a);
    return (a == WRAP_ADDR) ? ADDR_MIN : a + BURST_W;
  endfunction

  // Burst arbiter: a burst ends on the ack falling edge, then always passes through IDLE
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= ADDR_MIN;
      sdram_rd_addr <= ADDR_MIN;
      level         <= 24'd0;
      last_grant    <= GNT_READ;
      wr_ack_d1     <= 1'b0;
      rd_ack_d1     <= 1'b0;
    end else begin
      wr_ack_d1 <= sdram_wr_ack;
      rd_ack_d1 <= sdram_rd_ack;
      case (state)
        IDLE: begin
          if (init_end) begin
            if (wr_ok && (!rd_ok || last_grant == GNT_READ)) begin
              state        <= WRITE;
              sdram_wr_req <= 1'b1;
            end else if (rd_ok) begin
              state        <= READ;
              sdram_rd_req <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr_ack_fall) begin
            state         <= IDLE;
            sdram_wr_req  <= 1'b0;
            sdram_wr_addr <= next_addr(sdram_wr_addr);
            level         <= level + 24'd1;
            last_grant    <= GNT_WRITE;
          end
        end
        READ: begin
          if (rd_ack_fall) begin
            state         <= IDLE;
            sdram_rd_req  <= 1'b0;
            sdram_rd_addr <= next_addr(sdram_rd_addr);
            level         <= level - 24'd1;
            last_grant    <= GNT_READ;
          end
        end
        default: begin
          state        <= IDLE;
          sdram_wr_req <= 1'b0;
          sdram_rd_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Randomized bench for sdram_fifo_ctrl: an SDRAM responder plus a word-level FIFO model of the ring buffer.
module tb_sdram_fifo_ctrl;

  localparam int BURST = 10;
  localparam int AMIN  = 0;
  localparam int AMAX  = 999;
  localparam int THR   = 512;
  localparam int SPAN  = AMAX - AMIN + 1;
  localparam int CAP   = SPAN / BURST;

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_end = 1'b0;
  logic        read_valid = 1'b0;
  logic [9:0]  wr_fifo_usedw = 10'd0;
  logic [15:0] wr_fifo_rd_data = 16'd0;
  logic        wr_fifo_rd_en;
  logic [9:0]  rd_fifo_usedw = 10'd0;
  logic        rd_fifo_wr_en;
  logic [15:0] rd_fifo_wr_data;
  logic        sdram_wr_req;
  logic        sdram_wr_ack = 1'b0;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  wr_burst_len;
  logic [15:0] sdram_wr_data;
  logic        sdram_rd_req;
  logic        sdram_rd_ack = 1'b0;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  rd_burst_len;
  logic [15:0] sdram_rd_data = 16'd0;

  sdram_fifo_ctrl dut (
    .clk_100m        (clk_100m),
    .rst_n           (rst_n),
    .init_end        (init_end),
    .read_valid      (read_valid),
    .wr_fifo_usedw   (wr_fifo_usedw),
    .wr_fifo_rd_data (wr_fifo_rd_data),
    .wr_fifo_rd_en   (wr_fifo_rd_en),
    .rd_fifo_usedw   (rd_fifo_usedw),
    .rd_fifo_wr_en   (rd_fifo_wr_en),
    .rd_fifo_wr_data (rd_fifo_wr_data),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_wr_addr   (sdram_wr_addr),
    .wr_burst_len    (wr_burst_len),
    .sdram_wr_data   (sdram_wr_data),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_rd_addr   (sdram_rd_addr),
    .rd_burst_len    (rd_burst_len),
    .sdram_rd_data   (sdram_rd_data)
  );

  always #5 clk_100m = ~clk_100m;

  int errors = 0;
  int checks = 0;

  // Reference model: ring occupancy, burst pointers, arbitration history and the FIFO of stored words
  int          m_wr_addr = AMIN;
  int          m_rd_addr = AMIN;
  int          m_level = 0;
  bit          m_last_wr = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_words[$];
  logic [15:0] mem [0:1023];

  // Observations from the most recent served burst
  bit          s_seen, s_is_wr, s_dropped, s_extra;
  int          s_addr, s_pulses;
  logic [15:0] s_words[$];

  function automatic int adv(int a);
    return AMIN + ((a - AMIN + BURST) % SPAN);
  endfunction

  function automatic bit predict_wr();
    bit w_ok, r_ok;
    w_ok = (int'(wr_fifo_usedw) >= BURST) && (m_level < CAP);
    r_ok = read_valid && (int'(rd_fifo_usedw) < THR) && (m_level > 0);
    if (w_ok && r_ok) return !m_last_wr;
    return w_ok;
  endfunction

  task automatic reset_model();
    m_wr_addr = AMIN; m_rd_addr = AMIN; m_level = 0; m_last_wr = 1'b0;
    exp_q.delete();
  endtask

  // SDRAM side: wait for a request, ack it for one burst, then wait one edge for req to drop
  task automatic serve();
    int t = 0;
    s_seen = 0; s_dropped = 0; s_extra = 0; s_pulses = 0; s_is_wr = 0; s_addr = 0;
    s_words.delete();
    while (!sdram_wr_req && !sdram_rd_req && t < 100) begin
      @(negedge clk_100m);
      t++;
    end
    if (!sdram_wr_req && !sdram_rd_req) return;
    s_seen  = 1;
    s_is_wr = sdram_wr_req;
    s_addr  = s_is_wr ? int'(sdram_wr_addr) : int'(sdram_rd_addr);
    repeat ($urandom_range(0, 2)) @(negedge clk_100m);
    for (int i = 0; i < BURST; i++) begin
      if (s_is_wr) sdram_wr_ack = 1'b1;
      else begin
        sdram_rd_ack  = 1'b1;
        sdram_rd_data = mem[(s_addr + i) % 1024];
      end
      #1;
      if (s_is_wr) begin
        mem[(s_addr + i) % 1024] = sdram_wr_data;
        s_words.push_back(wr_fifo_rd_data);
        if (wr_fifo_rd_en) s_pulses++;
      end else begin
        s_words.push_back(rd_fifo_wr_data);
        if (rd_fifo_wr_en) s_pulses++;
      end
      @(negedge clk_100m);
      if (s_is_wr) wr_fifo_rd_data = 16'($urandom);
    end
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    #1;
    s_extra = wr_fifo_rd_en || rd_fifo_wr_en;
    @(negedge clk_100m);
    s_dropped = !sdram_wr_req && !sdram_rd_req;
  endtask

  // Apply a served burst to the model; for reads, exp_words gets the words the ring should return
  task automatic commit();
    logic [15:0] w;
    exp_words.delete();
    if (s_is_wr) begin
      foreach (s_words[i]) exp_q.push_back(s_words[i]);
      m_wr_addr = adv(m_wr_addr); m_level++; m_last_wr = 1'b1;
    end else begin
      for (int i = 0; i < BURST; i++) begin
        w = 'x;
        if (exp_q.size() > 0) w = exp_q.pop_front();
        exp_words.push_back(w);
      end
      m_rd_addr = adv(m_rd_addr); m_level--; m_last_wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [15:0] r;
    #3 rst_n = 1'b0;
    wr_fifo_rd_data = 16'($urandom);
    #1;
    checks++;
    if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: wr=%b rd=%b want 0 0", sdram_wr_req, sdram_rd_req);
    end
    checks++;
    if (sdram_wr_addr !== 24'(AMIN) || sdram_rd_addr !== 24'(AMIN)) begin
      errors++; $display("FAIL reset_addr: wr=%0d rd=%0d want %0d", sdram_wr_addr, sdram_rd_addr, AMIN);
    end
    checks++;
    if (wr_burst_len !== 10'(BURST) || rd_burst_len !== 10'(BURST)) begin
      errors++; $display("FAIL burst_len: wr=%0d rd=%0d want %0d", wr_burst_len, rd_burst_len, BURST);
    end
    checks++;
    if (sdram_wr_data !== wr_fifo_rd_data) begin
      errors++; $display("FAIL wr_data_path: got %h want %h", sdram_wr_data, wr_fifo_rd_data);
    end
    r = 16'($urandom);
    sdram_rd_data = r; sdram_wr_ack = 1'b1; sdram_rd_ack = 1'b1;
    #1;
    checks++;
    if (wr_fifo_rd_en !== 1'b1 || rd_fifo_wr_en !== 1'b1 || rd_fifo_wr_data !== r) begin
      errors++; $display("FAIL ack_path_hi: rd_en=%b wr_en=%b data=%h want 1 1 %h", wr_fifo_rd_en, rd_fifo_wr_en, rd_fifo_wr_data, r);
    end
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    #1;
    checks++;
    if (wr_fifo_rd_en !== 1'b0 || rd_fifo_wr_en !== 1'b0) begin
      errors++; $display("FAIL ack_path_lo: rd_en=%b wr_en=%b want 0 0", wr_fifo_rd_en, rd_fifo_wr_en);
    end
    repeat (3) @(negedge clk_100m);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_init_gate();
    bit any_req = 0;
    bit exp_wr;
    int exp_addr;
    wr_fifo_usedw = 10'd20;
    repeat (20) begin
      @(negedge clk_100m);
      if (sdram_wr_req || sdram_rd_req) any_req = 1;
    end
    checks++;
    if (any_req) begin
      errors++; $display("FAIL init_gate: req seen while init_end=0, want none");
    end
    init_end = 1'b1;
    exp_wr = predict_wr();
    exp_addr = m_wr_addr;
    @(negedge clk_100m);
    checks++;
    if (sdram_wr_req !== 1'b1 || sdram_wr_addr !== 24'(exp_addr)) begin
      errors++; $display("FAIL init_first_req: req=%b addr=%0d want 1 %0d", sdram_wr_req, sdram_wr_addr, exp_addr);
    end
    serve();
    wr_fifo_usedw = 10'd0;
    checks++;
    if (!s_seen || s_is_wr != exp_wr || s_addr != exp_addr || s_pulses != BURST || s_extra || !s_dropped) begin
      errors++; $display("FAIL init_burst: seen=%0d wr=%0d addr=%0d pulses=%0d extra=%0d dropped=%0d want 1 %0d %0d %0d 0 1",
                         s_seen, s_is_wr, s_addr, s_pulses, s_extra, s_dropped, exp_wr, exp_addr, BURST);
    end
    commit();
    checks++;
    if (sdram_wr_addr !== 24'(m_wr_addr)) begin
      errors++; $display("FAIL init_next_addr: got %0d want %0d", sdram_wr_addr, m_wr_addr);
    end
  endtask

  task automatic test_rd_threshold();
    bit any_req = 0;
    int exp_addr;
    read_valid = 1'b1;
    wr_fifo_usedw = 10'd0;
    rd_fifo_usedw = 10'(THR);
    repeat (20) begin
      @(negedge clk_100m);
      if (sdram_wr_req || sdram_rd_req) any_req = 1;
    end
    checks++;
    if (any_req) begin
      errors++; $display("FAIL rd_thr_block: req seen with rd_fifo_usedw=%0d, want none", THR);
    end
    rd_fifo_usedw = 10'(THR - 1);
    exp_addr = m_rd_addr;
    @(negedge clk_100m);
    checks++;
    if (sdram_rd_req !== 1'b1 || sdram_rd_addr !== 24'(exp_addr)) begin
      errors++; $display("FAIL rd_thr_grant: req=%b addr=%0d want 1 %0d", sdram_rd_req, sdram_rd_addr, exp_addr);
    end
    // Dropping the enables mid-burst must not cut the burst short
    read_valid = 1'b0;
    init_end = 1'b0;
    serve();
    init_end = 1'b1;
    checks++;
    if (!s_seen || s_is_wr || s_addr != exp_addr || s_pulses != BURST || s_extra || !s_dropped) begin
      errors++; $display("FAIL rd_thr_burst: seen=%0d wr=%0d addr=%0d pulses=%0d extra=%0d dropped=%0d want 1 0 %0d %0d 0 1",
                         s_seen, s_is_wr, s_addr, s_pulses, s_extra, s_dropped, exp_addr, BURST);
    end
    commit();
    foreach (exp_words[i]) begin
      checks++;
      if (s_words[i] !== exp_words[i]) begin
        errors++; $display("FAIL rd_thr_data[%0d]: got %h want %h", i, s_words[i], exp_words[i]);
      end
    end
  endtask

  task automatic test_alternate();
    bit exp_wr;
    int exp_addr;
    for (int n = 0; n < 10; n++) begin
      wr_fifo_usedw = 10'($urandom_range(BURST, 1023));
      read_valid    = ($urandom_range(0, 3) != 0);
      rd_fifo_usedw = 10'($urandom_range(0, THR - 1));
      exp_wr   = predict_wr();
      exp_addr = exp_wr ? m_wr_addr : m_rd_addr;
      serve();
      wr_fifo_usedw = 10'd0;
      read_valid = 1'b0;
      checks++;
      if (!s_seen || s_is_wr != exp_wr || s_addr != exp_addr || s_pulses != BURST || s_extra || !s_dropped) begin
        errors++; $display("FAIL alt_burst%0d: seen=%0d wr=%0d addr=%0d pulses=%0d extra=%0d dropped=%0d want 1 %0d %0d %0d 0 1",
                           n, s_seen, s_is_wr, s_addr, s_pulses, s_extra, s_dropped, exp_wr, exp_addr, BURST);
      end
      commit();
      foreach (exp_words[i]) begin
        checks++;
        if (s_words[i] !== exp_words[i]) begin
          errors++; $display("FAIL alt_data%0d[%0d]: got %h want %h", n, i, s_words[i], exp_words[i]);
        end
      end
    end
  endtask

  // Drain to empty, fill to capacity (wrapping the ring), check write stall, drain again, check read stall
  task automatic test_fill_drain();
    bit exp_wr, any_req;
    int exp_addr, iters;
    for (int phase = 0; phase < 3; phase++) begin
      iters = 0;
      while (((phase == 1) ? (m_level < CAP) : (m_level > 0)) && iters < 150) begin
        iters++;
        if (phase == 1) begin
          wr_fifo_usedw = 10'($urandom_range(BURST, 1023));
          read_valid = 1'b0;
        end else begin
          wr_fifo_usedw = 10'd0;
          read_valid = 1'b1;
          rd_fifo_usedw = 10'($urandom_range(0, THR - 1));
        end
        exp_wr   = predict_wr();
        exp_addr = exp_wr ? m_wr_addr : m_rd_addr;
        serve();
        checks++;
        if (!s_seen || s_is_wr != exp_wr || s_addr != exp_addr || s_pulses != BURST || s_extra || !s_dropped) begin
          errors++; $display("FAIL fill_burst p%0d: seen=%0d wr=%0d addr=%0d pulses=%0d extra=%0d dropped=%0d want 1 %0d %0d %0d 0 1",
                             phase, s_seen, s_is_wr, s_addr, s_pulses, s_extra, s_dropped, exp_wr, exp_addr, BURST);
        end
        if (!s_seen) break;
        commit();
        foreach (exp_words[i]) begin
          checks++;
          if (s_words[i] !== exp_words[i]) begin
            errors++; $display("FAIL fill_data p%0d[%0d]: got %h want %h", phase, i, s_words[i], exp_words[i]);
          end
        end
      end
      if (phase == 0) continue;
      if (phase == 1) begin
        wr_fifo_usedw = 10'($urandom_range(BURST, 1023));
        read_valid = 1'b0;
      end else begin
        wr_fifo_usedw = 10'd0;
        read_valid = 1'b1;
        rd_fifo_usedw = 10'd0;
      end
      any_req = 0;
      repeat (30) begin
        @(negedge clk_100m);
        if (sdram_wr_req || sdram_rd_req) any_req = 1;
      end
      checks++;
      if (any_req) begin
        errors++; $display("FAIL stall p%0d: req seen at level %0d, want none", phase, m_level);
      end
      checks++;
      if (sdram_wr_addr !== 24'(m_wr_addr) || sdram_rd_addr !== 24'(m_rd_addr)) begin
        errors++; $display("FAIL stall_addr p%0d: wr=%0d rd=%0d want %0d %0d", phase, sdram_wr_addr, sdram_rd_addr, m_wr_addr, m_rd_addr);
      end
    end
    wr_fifo_usedw = 10'd0;
    read_valid = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int t = 0;
    bit exp_wr, any_req;
    int exp_addr;
    read_valid = 1'b0;
    wr_fifo_usedw = 10'd20;
    while (!sdram_wr_req && t < 50) begin
      @(negedge clk_100m);
      t++;
    end
    checks++;
    if (!sdram_wr_req) begin
      errors++; $display("FAIL rst_mid_grant: wr_req=%b want 1", sdram_wr_req);
    end
    sdram_wr_ack = 1'b1;
    repeat (4) @(negedge clk_100m);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drop: wr=%b rd=%b want 0 0", sdram_wr_req, sdram_rd_req);
    end
    sdram_wr_ack = 1'b0;
    wr_fifo_usedw = 10'd0;
    @(negedge clk_100m);
    rst_n = 1'b1;
    reset_model();
    @(negedge clk_100m);
    checks++;
    if (sdram_wr_addr !== 24'(AMIN) || sdram_rd_addr !== 24'(AMIN)) begin
      errors++; $display("FAIL rst_mid_addr: wr=%0d rd=%0d want %0d", sdram_wr_addr, sdram_rd_addr, AMIN);
    end
    read_valid = 1'b1;
    rd_fifo_usedw = 10'd0;
    any_req = 0;
    repeat (20) begin
      @(negedge clk_100m);
      if (sdram_wr_req || sdram_rd_req) any_req = 1;
    end
    checks++;
    if (any_req) begin
      errors++; $display("FAIL rst_mid_level: req seen after reset with empty ring, want none");
    end
    for (int n = 0; n < 2; n++) begin
      read_valid    = (n == 1);
      wr_fifo_usedw = (n == 0) ? 10'd20 : 10'd0;
      exp_wr   = predict_wr();
      exp_addr = exp_wr ? m_wr_addr : m_rd_addr;
      serve();
      wr_fifo_usedw = 10'd0;
      checks++;
      if (!s_seen || s_is_wr != exp_wr || s_addr != exp_addr || s_pulses != BURST || s_extra || !s_dropped) begin
        errors++; $display("FAIL rst_after_burst%0d: seen=%0d wr=%0d addr=%0d pulses=%0d extra=%0d dropped=%0d want 1 %0d %0d %0d 0 1",
                           n, s_seen, s_is_wr, s_addr, s_pulses, s_extra, s_dropped, exp_wr, exp_addr, BURST);
      end
      commit();
      foreach (exp_words[i]) begin
        checks++;
        if (s_words[i] !== exp_words[i]) begin
          errors++; $display("FAIL rst_after_data[%0d]: got %h want %h", i, s_words[i], exp_words[i]);
        end
      end
    end
    any_req = 0;
    repeat (20) begin
      @(negedge clk_100m);
      if (sdram_wr_req || sdram_rd_req) any_req = 1;
    end
    checks++;
    if (any_req) begin
      errors++; $display("FAIL rst_after_empty: req seen with ring empty, want none");
    end
    read_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_rd_threshold();
    test_alternate();
    test_fill_drain();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
